// File: rtl/mem_arbiter_pkg.sv
// Shared types for the memory-port arbiter: FSM state codes and burst owner encoding.
package mem_arbiter_pkg;

   typedef enum logic [1:0] {
      ARB_IDLE = 2'd0,
      ARB_REQ  = 2'd1,
      ARB_RD   = 2'd2,
      ARB_WR   = 2'd3
   } arb_state_e;

   typedef enum logic {
      OWNER_IC = 1'b0,
      OWNER_DC = 1'b1
   } owner_e;

endpackage

// File: rtl/mem_arbiter_arb_rr2.sv
// Two-input grant logic for ICache/DCache memory requests.
// MEM_ARB_RR_EN selects round-robin with a last-grant pointer; otherwise fixed DC-over-IC priority.
module arb_rr2
   import mem_arbiter_pkg::*;
(
   input  logic clk,
   input  logic rst_n,
   input  logic en,
   input  logic req_ic,
   input  logic req_dc,
   output logic gnt_ic,
   output logic gnt_dc,
   output logic any
);

`ifdef MEM_ARB_RR_EN
   owner_e last_q, last_d;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) last_q <= OWNER_IC;
      else        last_q <= last_d;
   end

   // On a tie the requester not granted last wins; reset value makes DC win the first tie.
   always_comb begin
      gnt_dc = req_dc && (!req_ic || (last_q == OWNER_IC));
      gnt_ic = req_ic && !gnt_dc;
      last_d = last_q;
      if (en && (gnt_ic || gnt_dc)) last_d = gnt_dc ? OWNER_DC : OWNER_IC;
   end
`else
   logic unused;
   assign unused = &{1'b0, clk, rst_n, en};

   always_comb begin
      gnt_dc = req_dc;
      gnt_ic = req_ic && !req_dc;
   end
`endif

   assign any = gnt_ic || gnt_dc;

endmodule

// File: rtl/mem_arbiter.sv
// Shares the single memory port between ICache refills and DCache refills/writebacks.
// Build option: define MEM_ARB_RR_EN for round-robin arbitration (default fixed DC priority).
module mem_arbiter
   import mem_arbiter_pkg::*;
#(
   parameter int unsigned ADDR_WIDTH = 32,
   parameter int unsigned DATA_WIDTH = 128,
   parameter int unsigned BEATS      = 4
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic                  ic_req_valid,
   input  logic [ADDR_WIDTH-1:0] ic_req_addr,
   output logic                  ic_req_ready,
   output logic                  ic_resp_valid,
   output logic                  ic_resp_last,
   input  logic                  dc_req_valid,
   input  logic                  dc_req_rnw,
   input  logic [ADDR_WIDTH-1:0] dc_req_addr,
   output logic                  dc_req_ready,
   output logic                  dc_resp_valid,
   output logic                  dc_resp_last,
   input  logic                  dc_wdata_valid,
   input  logic [DATA_WIDTH-1:0] dc_wdata,
   output logic                  dc_wdata_ready,
   output logic [DATA_WIDTH-1:0] resp_data,
   output logic                  mem_req_valid,
   output logic                  mem_req_rnw,
   output logic [ADDR_WIDTH-1:0] mem_req_addr,
   input  logic                  mem_req_ready,
   output logic                  mem_wdata_valid,
   output logic [DATA_WIDTH-1:0] mem_wdata,
   input  logic                  mem_wdata_ready,
   input  logic                  mem_resp_valid,
   input  logic [DATA_WIDTH-1:0] mem_resp_data
);

   localparam int unsigned    CW        = $clog2(BEATS);
   localparam logic [CW-1:0] LAST_BEAT = CW'(BEATS - 1);

   arb_state_e            state_q, state_d;
   owner_e                owner_q, owner_d;
   logic                  rnw_q, rnw_d;
   logic [ADDR_WIDTH-1:0] addr_q, addr_d;
   logic [CW-1:0]         cnt_q, cnt_d;

   logic gnt_ic, gnt_dc, gnt_any;
   logic is_last;

   arb_rr2 u_arb (
      .clk    (clk),
      .rst_n  (reset),
      .en     (state_q == ARB_IDLE),
      .req_ic (ic_req_valid),
      .req_dc (dc_req_valid),
      .gnt_ic (gnt_ic),
      .gnt_dc (gnt_dc),
      .any    (gnt_any)
   );

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q <= ARB_IDLE;
         owner_q <= OWNER_IC;
         rnw_q   <= 1'b0;
         addr_q  <= '0;
         cnt_q   <= '0;
      end else begin
         state_q <= state_d;
         owner_q <= owner_d;
         rnw_q   <= rnw_d;
         addr_q  <= addr_d;
         cnt_q   <= cnt_d;
      end
   end

   assign resp_data = mem_resp_data;
   assign is_last   = (cnt_q == LAST_BEAT);

   always_comb begin
      state_d         = state_q;
      owner_d         = owner_q;
      rnw_d           = rnw_q;
      addr_d          = addr_q;
      cnt_d           = cnt_q;
      ic_req_ready    = 1'b0;
      dc_req_ready    = 1'b0;
      ic_resp_valid   = 1'b0;
      ic_resp_last    = 1'b0;
      dc_resp_valid   = 1'b0;
      dc_resp_last    = 1'b0;
      dc_wdata_ready  = 1'b0;
      mem_req_valid   = 1'b0;
      mem_req_rnw     = 1'b0;
      mem_req_addr    = '0;
      mem_wdata_valid = 1'b0;
      mem_wdata       = '0;

      unique case (state_q)
         ARB_IDLE: begin
            ic_req_ready = gnt_ic;
            dc_req_ready = gnt_dc;
            if (gnt_any) begin
               owner_d = gnt_dc ? OWNER_DC : OWNER_IC;
               rnw_d   = gnt_dc ? dc_req_rnw : 1'b1;
               addr_d  = gnt_dc ? dc_req_addr : ic_req_addr;
               state_d = ARB_REQ;
            end
         end
         ARB_REQ: begin
            mem_req_valid = 1'b1;
            mem_req_rnw   = rnw_q;
            mem_req_addr  = addr_q;
            if (mem_req_ready) begin
               cnt_d   = '0;
               state_d = rnw_q ? ARB_RD : ARB_WR;
            end
         end
         ARB_RD: begin
            // Memory cannot be stalled: every valid cycle is a beat for the owner.
            if (owner_q == OWNER_DC) begin
               dc_resp_valid = mem_resp_valid;
               dc_resp_last  = mem_resp_valid && is_last;
            end else begin
               ic_resp_valid = mem_resp_valid;
               ic_resp_last  = mem_resp_valid && is_last;
            end
            if (mem_resp_valid) begin
               cnt_d = cnt_q + 1'b1;
               if (is_last) state_d = ARB_IDLE;
            end
         end
         ARB_WR: begin
            mem_wdata_valid = dc_wdata_valid;
            mem_wdata       = dc_wdata;
            dc_wdata_ready  = mem_wdata_ready;
            if (dc_wdata_valid && mem_wdata_ready) begin
               cnt_d = cnt_q + 1'b1;
               if (is_last) state_d = ARB_IDLE;
            end
         end
         default: state_d = ARB_IDLE;
      endcase
   end

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed self-checking bench for mem_arbiter (honours MEM_ARB_RR_EN for the tie-break test).
module tb_mem_arbiter;

   logic         clk = 1'b0;
   logic         reset;
   logic         ic_req_valid, ic_req_ready, ic_resp_valid, ic_resp_last;
   logic [31:0]  ic_req_addr;
   logic         dc_req_valid, dc_req_rnw, dc_req_ready, dc_resp_valid, dc_resp_last;
   logic [31:0]  dc_req_addr;
   logic         dc_wdata_valid, dc_wdata_ready;
   logic [127:0] dc_wdata, resp_data;
   logic         mem_req_valid, mem_req_rnw, mem_req_ready;
   logic [31:0]  mem_req_addr;
   logic         mem_wdata_valid, mem_wdata_ready;
   logic [127:0] mem_wdata;
   logic         mem_resp_valid;
   logic [127:0] mem_resp_data;

   int unsigned n_cmp = 0;
   int unsigned n_err = 0;

   logic [127:0] wd [4];

   always #5 clk = ~clk;

   mem_arbiter #(.ADDR_WIDTH(32), .DATA_WIDTH(128), .BEATS(4)) dut (
      .clk             (clk),
      .reset           (reset),
      .ic_req_valid    (ic_req_valid),
      .ic_req_addr     (ic_req_addr),
      .ic_req_ready    (ic_req_ready),
      .ic_resp_valid   (ic_resp_valid),
      .ic_resp_last    (ic_resp_last),
      .dc_req_valid    (dc_req_valid),
      .dc_req_rnw      (dc_req_rnw),
      .dc_req_addr     (dc_req_addr),
      .dc_req_ready    (dc_req_ready),
      .dc_resp_valid   (dc_resp_valid),
      .dc_resp_last    (dc_resp_last),
      .dc_wdata_valid  (dc_wdata_valid),
      .dc_wdata        (dc_wdata),
      .dc_wdata_ready  (dc_wdata_ready),
      .resp_data       (resp_data),
      .mem_req_valid   (mem_req_valid),
      .mem_req_rnw     (mem_req_rnw),
      .mem_req_addr    (mem_req_addr),
      .mem_req_ready   (mem_req_ready),
      .mem_wdata_valid (mem_wdata_valid),
      .mem_wdata       (mem_wdata),
      .mem_wdata_ready (mem_wdata_ready),
      .mem_resp_valid  (mem_resp_valid),
      .mem_resp_data   (mem_resp_data)
   );

   task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic settle();
      #1;
   endtask

   initial begin
      wd[0] = 128'hA0A0_A0A0_0000_0000_0000_0000_0000_000A;
      wd[1] = 128'hB1B1_B1B1_0000_0000_0000_0000_0000_000B;
      wd[2] = 128'hC2C2_C2C2_0000_0000_0000_0000_0000_000C;
      wd[3] = 128'hD3D3_D3D3_0000_0000_0000_0000_0000_000D;

      reset = 1'b0;
      ic_req_valid = 1'b0; ic_req_addr = '0;
      dc_req_valid = 1'b0; dc_req_rnw = 1'b0; dc_req_addr = '0;
      dc_wdata_valid = 1'b0; dc_wdata = '0;
      mem_req_ready = 1'b0; mem_wdata_ready = 1'b0;
      mem_resp_valid = 1'b0; mem_resp_data = '0;

      // reset state
      tick(); tick(); settle();
      chk("rst_mem_req_valid", mem_req_valid, 1'b0);
      chk("rst_ic_req_ready", ic_req_ready, 1'b0);
      chk("rst_dc_req_ready", dc_req_ready, 1'b0);
      chk("rst_ic_resp_valid", ic_resp_valid, 1'b0);
      chk("rst_mem_wdata_valid", mem_wdata_valid, 1'b0);
      reset = 1'b1;

      // 1: IC read, mem_req_ready after 2 cycles, beats with gaps
      tick();
      ic_req_valid = 1'b1; ic_req_addr = 32'h0000_1000;
      settle();
      chk("t1_ic_req_ready", ic_req_ready, 1'b1);
      chk("t1_dc_req_ready", dc_req_ready, 1'b0);
      chk("t1_no_req_yet", mem_req_valid, 1'b0);
      tick();
      ic_req_valid = 1'b0;
      settle();
      chk("t1_mem_req_valid", mem_req_valid, 1'b1);
      chk("t1_mem_req_addr", mem_req_addr, 32'h0000_1000);
      chk("t1_mem_req_rnw", mem_req_rnw, 1'b1);
      chk("t1_no_ready_in_req", ic_req_ready, 1'b0);
      tick(); settle();
      chk("t1_req_held", mem_req_valid, 1'b1);
      mem_req_ready = 1'b1;
      tick();
      mem_req_ready = 1'b0;
      settle();
      chk("t1_req_dropped", mem_req_valid, 1'b0);
      for (int b = 0; b < 4; b++) begin
         chk("t1_gap_no_resp", ic_resp_valid, 1'b0);
         tick();
         mem_resp_valid = 1'b1; mem_resp_data = 128'h100 + 128'(b);
         settle();
         chk("t1_ic_resp_valid", ic_resp_valid, 1'b1);
         chk("t1_ic_resp_last", ic_resp_last, (b == 3));
         chk("t1_dc_resp_valid", dc_resp_valid, 1'b0);
         chk("t1_resp_data", resp_data, 128'h100 + 128'(b));
         tick();
         mem_resp_valid = 1'b0;
         settle();
      end
      chk("t1_idle_after", mem_req_valid, 1'b0);

      // 5: stray mem_resp_valid in IDLE and REQ, then a full burst checks the counter
      mem_resp_valid = 1'b1; mem_resp_data = 128'h55;
      settle();
      chk("t5_idle_ic_resp", ic_resp_valid, 1'b0);
      chk("t5_idle_dc_resp", dc_resp_valid, 1'b0);
      ic_req_valid = 1'b1; ic_req_addr = 32'h0000_3000;
      tick();
      ic_req_valid = 1'b0;
      settle();
      chk("t5_req_ic_resp", ic_resp_valid, 1'b0);
      chk("t5_req_addr", mem_req_addr, 32'h0000_3000);
      mem_req_ready = 1'b1;
      tick();
      mem_req_ready = 1'b0;
      for (int b = 0; b < 4; b++) begin
         mem_resp_data = 128'(b);
         settle();
         chk("t5_ic_resp_valid", ic_resp_valid, 1'b1);
         chk("t5_ic_resp_last", ic_resp_last, (b == 3));
         tick();
      end
      mem_resp_valid = 1'b0;
      settle();
      chk("t5_idle_after", ic_resp_valid, 1'b0);

      // 2: DC writeback with mem_wdata_ready toggling 1/0
      dc_req_valid = 1'b1; dc_req_rnw = 1'b0; dc_req_addr = 32'h0000_2040;
      settle();
      chk("t2_dc_req_ready", dc_req_ready, 1'b1);
      chk("t2_ic_req_ready", ic_req_ready, 1'b0);
      tick();
      dc_req_valid = 1'b0;
      settle();
      chk("t2_mem_req_valid", mem_req_valid, 1'b1);
      chk("t2_mem_req_rnw", mem_req_rnw, 1'b0);
      chk("t2_mem_req_addr", mem_req_addr, 32'h0000_2040);
      mem_req_ready = 1'b1;
      tick();
      mem_req_ready = 1'b0;
      begin
         int unsigned fires;
         fires = 0;
         for (int k = 0; k < 20 && fires < 4; k++) begin
            dc_wdata_valid = 1'b1;
            dc_wdata = wd[fires];
            mem_wdata_ready = (k % 2 == 0);
            settle();
            chk("t2_mem_wdata_valid", mem_wdata_valid, 1'b1);
            chk("t2_mem_wdata", mem_wdata, wd[fires]);
            chk("t2_dc_wdata_ready", dc_wdata_ready, mem_wdata_ready);
            if (mem_wdata_ready) fires++;
            tick();
         end
      end
      dc_wdata_valid = 1'b1; mem_wdata_ready = 1'b1;
      settle();
      chk("t2_idle_wdata_valid", mem_wdata_valid, 1'b0);
      chk("t2_idle_wdata_ready", dc_wdata_ready, 1'b0);
      dc_wdata_valid = 1'b0; mem_wdata_ready = 1'b0;

      // 4: reset during beat 2 of an IC read
      ic_req_valid = 1'b1; ic_req_addr = 32'h0000_4000;
      tick();
      ic_req_valid = 1'b0; mem_req_ready = 1'b1;
      tick();
      mem_req_ready = 1'b0; mem_resp_valid = 1'b1;
      settle();
      chk("t4_beat1", ic_resp_valid, 1'b1);
      tick(); settle();
      chk("t4_beat2", ic_resp_valid, 1'b1);
      chk("t4_beat2_last", ic_resp_last, 1'b0);
      reset = 1'b0;
      settle();
      chk("t4_rst_resp", ic_resp_valid, 1'b0);
      chk("t4_rst_req", mem_req_valid, 1'b0);
      tick();
      reset = 1'b1;
      settle();
      chk("t4_rel_ic_resp", ic_resp_valid, 1'b0);
      chk("t4_rel_dc_resp", dc_resp_valid, 1'b0);
      chk("t4_rel_req", mem_req_valid, 1'b0);
      tick(); settle();
      chk("t4_rel2_ic_resp", ic_resp_valid, 1'b0);
      mem_resp_valid = 1'b0;

      // 6: back-to-back DC reads (first also proves normal grant after reset)
      dc_req_valid = 1'b1; dc_req_rnw = 1'b1; dc_req_addr = 32'h0000_5000;
      settle();
      chk("t6_first_grant", dc_req_ready, 1'b1);
      tick(); settle();
      chk("t6_no_ready_in_req", dc_req_ready, 1'b0);
      chk("t6_req_addr", mem_req_addr, 32'h0000_5000);
      mem_req_ready = 1'b1;
      tick();
      mem_req_ready = 1'b0; mem_resp_valid = 1'b1;
      for (int b = 0; b < 4; b++) begin
         settle();
         chk("t6_dc_resp_valid", dc_resp_valid, 1'b1);
         chk("t6_ic_resp_valid", ic_resp_valid, 1'b0);
         chk("t6_dc_resp_last", dc_resp_last, (b == 3));
         chk("t6_no_ready_in_rd", dc_req_ready, 1'b0);
         tick();
      end
      mem_resp_valid = 1'b0;
      settle();
      chk("t6_second_grant", dc_req_ready, 1'b1);
      tick();
      dc_req_valid = 1'b0;
      reset = 1'b0;
      settle();
      tick();
      reset = 1'b1;

      // 3: IC and DC both held valid
      ic_req_valid = 1'b1; ic_req_addr = 32'h0000_6000;
      dc_req_valid = 1'b1; dc_req_rnw = 1'b1; dc_req_addr = 32'h0000_7000;
      for (int g = 0; g < 4; g++) begin
         logic exp_dc;
`ifdef MEM_ARB_RR_EN
         exp_dc = (g % 2 == 0);
`else
         exp_dc = 1'b1;
`endif
         settle();
         chk("t3_dc_req_ready", dc_req_ready, exp_dc);
         chk("t3_ic_req_ready", ic_req_ready, !exp_dc);
         tick(); settle();
         chk("t3_mem_req_addr", mem_req_addr, exp_dc ? 32'h0000_7000 : 32'h0000_6000);
         mem_req_ready = 1'b1;
         tick();
         mem_req_ready = 1'b0; mem_resp_valid = 1'b1;
         for (int b = 0; b < 4; b++) begin
            settle();
            if (b == 0) begin
               chk("t3_dc_resp_valid", dc_resp_valid, exp_dc);
               chk("t3_ic_resp_valid", ic_resp_valid, !exp_dc);
            end
            tick();
         end
         mem_resp_valid = 1'b0;
      end
      ic_req_valid = 1'b0; dc_req_valid = 1'b0;
      tick();

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
